fetch_program_counter: RTL and testbench

- Program-counter register and instruction-fetch sequencer for the fe stage.
- Sits directly downstream of the PC input mux: consumes its next-PC value and holds the architectural PC.
- Issues instruction-memory requests over a valid/ready handshake, captures the response, and presents one instruction at a time to decode/execute.
- Checks jump/branch target alignment and counts retired instructions.

---
 rtl/fetch_program_counter.sv | 104 ++++++++++
 tb/tb_fetch_program_counter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_program_counter.sv
// Program counter and instruction-fetch sequencer for the fe stage: fetches one
// instruction at a time over a valid/ready request, holds it until commit.
module fetch_program_counter #(
    parameter logic [31:0] RESET_VECTOR = 32'h0040_0000,
    parameter int          COUNT_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            program_counter_new,
    input  logic                   commit,
    input  logic                   halt,
    output logic                   imem_req_valid,
    output logic [31:0]            imem_req_addr,
    input  logic                   imem_req_ready,
    input  logic                   imem_rsp_valid,
    input  logic [31:0]            imem_rsp_data,
    output logic                   instr_valid,
    output logic [31:0]            instr,
    output logic [31:0]            program_counter,
    output logic [31:0]            program_counter_plus_4,
    output logic                   misaligned_fault,
    output logic [31:0]            fault_addr,
    output logic [COUNT_WIDTH-1:0] retired_count,
    output logic [2:0]             fsm_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WAIT   = 3'd2,
        EXEC   = 3'd3,
        HALTED = 3'd4,
        FAULT  = 3'd5
    } state_t;

    state_t state;

    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    // Handshake: a request transfers on any rising edge where imem_req_valid and
    // imem_req_ready are both 1; while valid is 1 without ready, the address is
    // held. A response is taken only in WAIT, on a rising edge with imem_rsp_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            program_counter  <= RESET_VECTOR;
            instr            <= 32'h0;
            instr_valid      <= 1'b0;
            imem_req_valid   <= 1'b0;
            misaligned_fault <= 1'b0;
            fault_addr       <= 32'h0;
            retired_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state          <= FETCH;
                    imem_req_valid <= 1'b1;
                end
                FETCH: begin
                    if (imem_req_ready) begin
                        state          <= WAIT;
                        imem_req_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        instr       <= imem_rsp_data;
                        instr_valid <= 1'b1;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    if (commit) begin
                        retired_count <= retired_count + COUNT_ONE;
                        instr_valid   <= 1'b0;
                        // halt wins over a bad target; a bad target never reaches the PC
                        if (halt) begin
                            state <= HALTED;
                        end else if (program_counter_new[1:0] != 2'b00) begin
                            state            <= FAULT;
                            misaligned_fault <= 1'b1;
                            fault_addr       <= program_counter_new;
                        end else begin
                            program_counter <= program_counter_new;
                            imem_req_valid  <= 1'b1;
                            state           <= FETCH;
                        end
                    end
                end
                HALTED, FAULT: begin
                    state <= state;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign imem_req_addr          = program_counter;
    assign program_counter_plus_4 = program_counter + 32'd4;
    assign fsm_state              = state;

endmodule

// File: tb/tb_fetch_program_counter.sv
// Randomized bench for fetch_program_counter: a transaction-level model predicts
// request addresses and captured instructions; a monitor checks them as they appear.
module tb_fetch_program_counter;

    localparam logic [31:0] RV = 32'h0040_0000;
    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_WAIT = 3'd2,
                           S_EXEC = 3'd3, S_HALTED = 3'd4, S_FAULT = 3'd5;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] program_counter_new = 32'h0;
    logic        commit = 1'b0;
    logic        halt = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] program_counter;
    logic [31:0] program_counter_plus_4;
    logic        misaligned_fault;
    logic [31:0] fault_addr;
    logic [31:0] retired_count;
    logic [2:0]  fsm_state;

    fetch_program_counter #(.RESET_VECTOR(RV), .COUNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .program_counter_new(program_counter_new), .commit(commit), .halt(halt),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid), .instr(instr),
        .program_counter(program_counter), .program_counter_plus_4(program_counter_plus_4),
        .misaligned_fault(misaligned_fault), .fault_addr(fault_addr),
        .retired_count(retired_count), .fsm_state(fsm_state)
    );

    // scoreboard
    int tests = 0;
    int fails = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_instr_q[$];

    // reference model: architectural view only
    logic [31:0] m_pc, m_count, m_fault_addr, m_last_instr;
    logic        m_fault;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // monitor: pops expectations whenever the DUT presents a request or an instruction
    logic        prev_req = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic        prev_iv = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_req = 1'b0;
            prev_iv  = 1'b0;
        end else begin
            if (imem_req_valid) begin
                if (prev_req) check("req_addr_stable", imem_req_addr, prev_addr);
                if (imem_req_ready) begin
                    if (exp_addr_q.size() == 0) begin
                        check("unexpected_request", {31'h0, imem_req_valid}, 32'h0);
                    end else begin
                        logic [31:0] ea;
                        ea = exp_addr_q.pop_front();
                        check("req_addr", imem_req_addr, ea);
                        check("req_plus_4", program_counter_plus_4, ea + 32'd4);
                    end
                end
            end
            if (instr_valid && !prev_iv) begin
                if (exp_instr_q.size() == 0) begin
                    check("unexpected_instr_valid", {31'h0, instr_valid}, 32'h0);
                end else begin
                    check("instr_data", instr, exp_instr_q.pop_front());
                end
            end
            prev_req  = imem_req_valid && !imem_req_ready;
            prev_addr = imem_req_addr;
            prev_iv   = instr_valid;
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, {29'h0, fsm_state}, {29'h0, S_IDLE});
        check({tag, "_pc"}, program_counter, RV);
        check({tag, "_instr"}, instr, 32'h0);
        check({tag, "_instr_valid"}, {31'h0, instr_valid}, 32'h0);
        check({tag, "_req_valid"}, {31'h0, imem_req_valid}, 32'h0);
        check({tag, "_fault"}, {31'h0, misaligned_fault}, 32'h0);
        check({tag, "_fault_addr"}, fault_addr, 32'h0);
        check({tag, "_count"}, retired_count, 32'h0);
    endtask

    // driver: reset, then first request must appear one cycle after release
    task automatic do_reset();
        rst_n = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        commit = 1'b0;
        halt = 1'b0;
        exp_addr_q.delete();
        exp_instr_q.delete();
        m_pc = RV; m_count = 0; m_fault = 1'b0; m_fault_addr = 0; m_last_instr = 0;
        repeat (3) tick();
        check_reset_values("reset");
        rst_n = 1'b1;
        exp_addr_q.push_back(RV);
        tick();
        check("first_req_valid", {31'h0, imem_req_valid}, 32'h1);
        check("first_req_addr", imem_req_addr, RV);
    endtask

    // driver: serve one fetch; ready after ready_dly cycles, response rsp_dly cycles later
    task automatic fetch_one(input logic [31:0] data, input int ready_dly,
                             input int rsp_dly, input bit spurious);
        int n = 0;
        while (!imem_req_valid && n < 20) begin
            tick();
            n++;
        end
        check("req_wait_timeout", {31'h0, imem_req_valid}, 32'h1);
        for (int i = 0; i < ready_dly; i++) begin
            imem_req_ready = 1'b0;
            imem_rsp_valid = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            imem_rsp_data  = 32'hDEAD_0000 | $urandom_range(0, 16'hFFFF);
            tick();
            check("req_held_valid", {31'h0, imem_req_valid}, 32'h1);
            check("no_early_instr", {31'h0, instr_valid}, 32'h0);
        end
        imem_rsp_valid = spurious;
        imem_rsp_data  = 32'hBAD0_BAD0;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        for (int i = 0; i < rsp_dly; i++) tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        exp_instr_q.push_back(data);
        m_last_instr = data;
        tick();
        imem_rsp_valid = 1'b0;
        check("instr_valid_up", {31'h0, instr_valid}, 32'h1);
    endtask

    task automatic do_commit(input logic [31:0] target, input bit h);
        program_counter_new = target;
        halt = h;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        halt = 1'b0;
        m_count = m_count + 1;
        if (h) begin
            check("halt_state", {29'h0, fsm_state}, {29'h0, S_HALTED});
        end else if (target[1:0] != 2'b00) begin
            m_fault = 1'b1;
            m_fault_addr = target;
            check("fault_state", {29'h0, fsm_state}, {29'h0, S_FAULT});
        end else begin
            m_pc = target;
            exp_addr_q.push_back(target);
            check("commit_req_latency", {31'h0, imem_req_valid}, 32'h1);
        end
        check("retired_count", retired_count, m_count);
        check("pc", program_counter, m_pc);
        check("plus_4", program_counter_plus_4, m_pc + 32'd4);
        check("fault_flag", {31'h0, misaligned_fault}, {31'h0, m_fault});
        check("fault_addr", fault_addr, m_fault_addr);
        check("instr_valid_down", {31'h0, instr_valid}, 32'h0);
    endtask

    // terminal states: commits and responses must change nothing
    task automatic poke_terminal(input logic [2:0] exp_state, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            commit = 1'b1;
            program_counter_new = $urandom();
            imem_req_ready = 1'b1;
            imem_rsp_valid = 1'b1;
            imem_rsp_data = $urandom();
            tick();
            check("term_state", {29'h0, fsm_state}, {29'h0, exp_state});
            check("term_req_valid", {31'h0, imem_req_valid}, 32'h0);
            check("term_instr_valid", {31'h0, instr_valid}, 32'h0);
            check("term_count", retired_count, m_count);
            check("term_pc", program_counter, m_pc);
            check("term_instr", instr, m_last_instr);
        end
        commit = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] t;
        do_reset();

        // first instruction: immediate ready, response one cycle later
        fetch_one(32'h0000_0013, 0, 0, 1'b0);
        check("first_count", retired_count, 32'h0);
        do_commit(32'h0040_0010, 1'b0);
        check("plus_4_0x400014", program_counter_plus_4, 32'h0040_0014);

        // stalled request with spurious responses
        fetch_one($urandom(), 5, 1, 1'b1);

        // random legal traffic, including idle cycles in EXEC
        for (int k = 0; k < 30; k++) begin
            t = $urandom();
            t[1:0] = 2'b00;
            if (k % 7 == 3) t = 32'h0;
            do_commit(t, 1'b0);
            fetch_one($urandom(), $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)));
            for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
                tick();
                check("exec_hold_valid", {31'h0, instr_valid}, 32'h1);
                check("exec_hold_instr", instr, m_last_instr);
            end
        end

        // PC wrap
        do_commit(32'hFFFF_FFFC, 1'b0);
        check("wrap_plus_4", program_counter_plus_4, 32'h0);
        fetch_one($urandom(), 1, 0, 1'b0);
        do_commit(32'h0, 1'b0);
        check("wrap_req_addr", imem_req_addr, 32'h0);
        fetch_one($urandom(), 0, 2, 1'b0);

        // misaligned target
        do_commit(32'h0040_0022, 1'b0);
        check("fault_addr_0x400022", fault_addr, 32'h0040_0022);
        poke_terminal(S_FAULT, 5);

        // halt, then reset asynchronously while in WAIT
        do_reset();
        fetch_one($urandom(), 0, 0, 1'b0);
        do_commit($urandom(), 1'b1);
        check("halt_count_once", retired_count, 32'h1);
        poke_terminal(S_HALTED, 5);
        do_reset();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        check("in_wait", {29'h0, fsm_state}, {29'h0, S_WAIT});
        #1 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        do_reset();
        fetch_one($urandom(), $urandom_range(0, 2), $urandom_range(0, 2), 1'b1);
        do_commit(32'h0000_1000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
